// File: rtl/hub75_pkg.sv
// HUB75 scan scheduler shared definitions.
// Geometry defaults, framebuffer word layout and FSM states.
package hub75_pkg;

    localparam int DEF_COLS    = 32;
    localparam int DEF_ROWS    = 16;
    localparam int DEF_BITS    = 4;
    localparam int DEF_BASE_OE = 8;

    // fb_rd_data is six BITS-wide fields, field f at [f*BITS +: BITS]
    localparam int NFIELDS = 6;
    localparam int F_R_TOP = 0;
    localparam int F_G_TOP = 1;
    localparam int F_B_TOP = 2;
    localparam int F_R_BOT = 3;
    localparam int F_G_BOT = 4;
    localparam int F_B_BOT = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREFETCH,
        S_SHIFT,
        S_BLANK,
        S_LATCH,
        S_DISPLAY
    } state_t;

endpackage

// File: rtl/hub75_bcm_timer.sv
// BCM on-time timer for the HUB75 scheduler.
// Loadable down-counter; done while the count sits at zero.
module hub75_bcm_timer #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    // load N-1 so that done rises on the Nth cycle after the load
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/hub75_scan_sched.sv
// HUB75 scan scheduler: framebuffer reads, bitplane shift,
// latch and BCM display, with frame-end bank swapping.
module hub75_scan_sched
    import hub75_pkg::*;
#(
    parameter int COLS    = DEF_COLS,
    parameter int ROWS    = DEF_ROWS,
    parameter int BITS    = DEF_BITS,
    parameter int BASE_OE = DEF_BASE_OE
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 en,
    input  logic                                 swap_req,
    output logic                                 swap_ack,
    output logic                                 frame_start,
    output logic                                 fb_bank,
    output logic                                 fb_rd_en,
    output logic [$clog2(ROWS)+$clog2(COLS):0]   fb_rd_addr,
    input  logic [6*BITS-1:0]                    fb_rd_data,
    output logic [1:0]                           mat_r,
    output logic [1:0]                           mat_g,
    output logic [1:0]                           mat_b,
    output logic [$clog2(ROWS)-1:0]              mat_row,
    output logic                                 mat_clk,
    output logic                                 mat_lat,
    output logic                                 mat_oe
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam int PW = (BITS > 1) ? $clog2(BITS) : 1;
    localparam int TW = $clog2(BASE_OE << (BITS - 1)) + 1;

    state_t               state;
    logic [RW-1:0]        row;
    logic [PW-1:0]        plane;
    logic [CW-1:0]        col;
    logic                 ph;
    logic [NFIELDS-1:0]   px;
    logic [NFIELDS-1:0]   hold;
    logic [NFIELDS-1:0]   rgb;
    logic                 last_plane;
    logic                 last_row;
    logic                 frame_end;
    logic                 swap_now;
    logic                 nxt_bank;
    logic [PW-1:0]        nxt_plane;
    logic [RW-1:0]        nxt_row;
    logic [TW-1:0]        oe_len;
    logic [TW-1:0]        oe_load;
    logic                 tmr_load;
    logic                 tmr_done;

    // current plane's bit of every colour field
    for (genvar f = 0; f < NFIELDS; f++) begin : g_px
        logic [BITS-1:0] fld;
        assign fld   = fb_rd_data[f*BITS +: BITS];
        assign px[f] = fld[plane];
    end

    // phase 0 shows the RAM word directly; phase 1 holds it
    assign rgb   = (state == S_SHIFT && !ph) ? px : hold;
    assign mat_r = {rgb[F_R_BOT], rgb[F_R_TOP]};
    assign mat_g = {rgb[F_G_BOT], rgb[F_G_TOP]};
    assign mat_b = {rgb[F_B_BOT], rgb[F_B_TOP]};

    // plane/row advance and frame-end swap decision
    always_comb begin
        last_plane = (plane == PW'(BITS - 1));
        last_row   = (row == RW'(ROWS - 1));
        frame_end  = last_plane && last_row;
        nxt_plane  = last_plane ? '0 : plane + PW'(1);
        nxt_row    = row;
        if (last_plane) begin
            nxt_row = last_row ? '0 : row + RW'(1);
        end
        swap_now = frame_end && swap_req;
        nxt_bank = fb_bank ^ swap_now;
    end

    assign tmr_load = (state == S_LATCH);
    assign oe_len   = TW'(BASE_OE) << plane;
    assign oe_load  = oe_len - TW'(1);

    hub75_bcm_timer #(
        .W(TW)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (tmr_load),
        .load_val(oe_load),
        .done    (tmr_done)
    );

    // scan FSM; every panel/RAM output is registered here
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            row         <= '0;
            plane       <= '0;
            col         <= '0;
            ph          <= 1'b0;
            hold        <= '0;
            fb_bank     <= 1'b0;
            swap_ack    <= 1'b0;
            frame_start <= 1'b0;
            fb_rd_en    <= 1'b0;
            fb_rd_addr  <= '0;
            mat_row     <= '0;
            mat_clk     <= 1'b0;
            mat_lat     <= 1'b0;
            mat_oe      <= 1'b1;
        end else begin
            swap_ack    <= 1'b0;
            frame_start <= 1'b0;
            fb_rd_en    <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    mat_clk <= 1'b0;
                    mat_lat <= 1'b0;
                    mat_oe  <= 1'b1;
                    if (en) begin
                        state       <= S_PREFETCH;
                        col         <= '0;
                        ph          <= 1'b0;
                        fb_rd_en    <= 1'b1;
                        fb_rd_addr  <= {fb_bank, row, {CW{1'b0}}};
                        frame_start <= (row == '0) && (plane == '0);
                    end
                end
                S_PREFETCH: begin
                    state <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (!ph) begin
                        ph      <= 1'b1;
                        mat_clk <= 1'b1;
                        hold    <= px;
                        if (col != CW'(COLS - 1)) begin
                            fb_rd_en   <= 1'b1;
                            fb_rd_addr <= {fb_bank, row, col + CW'(1)};
                        end
                    end else begin
                        ph      <= 1'b0;
                        mat_clk <= 1'b0;
                        if (col == CW'(COLS - 1)) begin
                            state   <= S_BLANK;
                            mat_row <= row;
                        end else begin
                            col <= col + CW'(1);
                        end
                    end
                end
                S_BLANK: begin
                    state   <= S_LATCH;
                    mat_lat <= 1'b1;
                end
                S_LATCH: begin
                    state   <= S_DISPLAY;
                    mat_lat <= 1'b0;
                    mat_oe  <= 1'b0;
                end
                S_DISPLAY: begin
                    if (tmr_done) begin
                        mat_oe <= 1'b1;
                        plane  <= nxt_plane;
                        row    <= nxt_row;
                        if (en) begin
                            state       <= S_PREFETCH;
                            col         <= '0;
                            ph          <= 1'b0;
                            fb_bank     <= nxt_bank;
                            swap_ack    <= swap_now;
                            fb_rd_en    <= 1'b1;
                            fb_rd_addr  <= {nxt_bank, nxt_row, {CW{1'b0}}};
                            frame_start <= (nxt_row == '0) && (nxt_plane == '0);
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hub75_scan_sched.sv
// Bench for hub75_scan_sched: random framebuffer contents,
// per-plane panel reconstruction against a framebuffer model.
module tb_hub75_scan_sched;

    localparam int COLS    = 4;
    localparam int ROWS    = 2;
    localparam int BITS    = 2;
    localparam int BASE_OE = 2;
    localparam int CW      = 2;
    localparam int RW      = 1;
    localparam int AW      = 1 + RW + CW;
    localparam int DW      = 6 * BITS;
    localparam int FRAME   = ROWS * ((3 + 2 * COLS) * BITS
                                     + BASE_OE * ((1 << BITS) - 1));

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          swap_req;
    logic          swap_ack;
    logic          frame_start;
    logic          fb_bank;
    logic          fb_rd_en;
    logic [AW-1:0] fb_rd_addr;
    logic [DW-1:0] fb_rd_data;
    logic [1:0]    mat_r;
    logic [1:0]    mat_g;
    logic [1:0]    mat_b;
    logic [RW-1:0] mat_row;
    logic          mat_clk;
    logic          mat_lat;
    logic          mat_oe;

    logic [DW-1:0] ram [2][ROWS][COLS];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            m_idx;
    logic          m_bank;
    bit            at_pf;
    int            fs_cyc[$];
    logic [1:0]    pix_r;

    hub75_scan_sched #(
        .COLS(COLS), .ROWS(ROWS), .BITS(BITS), .BASE_OE(BASE_OE)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .swap_req(swap_req),
        .swap_ack(swap_ack), .frame_start(frame_start),
        .fb_bank(fb_bank), .fb_rd_en(fb_rd_en),
        .fb_rd_addr(fb_rd_addr), .fb_rd_data(fb_rd_data),
        .mat_r(mat_r), .mat_g(mat_g), .mat_b(mat_b),
        .mat_row(mat_row), .mat_clk(mat_clk),
        .mat_lat(mat_lat), .mat_oe(mat_oe)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // synchronous RAM: word valid one cycle after the strobe, junk otherwise
    always @(posedge clk) begin
        if (fb_rd_en)
            fb_rd_data <= ram[fb_rd_addr[AW-1]][fb_rd_addr[AW-2:CW]][fb_rd_addr[CW-1:0]];
        else
            fb_rd_data <= DW'($urandom);
    end

    function automatic logic bit_of(input logic [31:0] v, input int i);
        logic [31:0] t;
        t = v >> i;
        return t[0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // follow one plane from PREFETCH to the end of its OE-low run
    task automatic scan_plane(input bit exp_swap, input int drop_en);
        int            r, p, n, rises, oe_lo, lats, acks, fs_n, c;
        bit            found, ended;
        logic [AW-1:0] prev_addr, ea;
        logic          prev_clk;
        logic [5:0]    obs, expv;
        logic [DW-1:0] word;
        r = (m_idx / BITS) % ROWS;
        p = m_idx % BITS;
        if (exp_swap) m_bank = ~m_bank;
        found = at_pf;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            found = fb_rd_en && !mat_clk;
        end
        chk("prefetch_seen", 32'(found), 1);
        if (!found) return;
        ea = {m_bank, r[RW-1:0], {CW{1'b0}}};
        chk("pf_addr", 32'(fb_rd_addr), 32'(ea));
        chk("pf_frame_start", 32'(frame_start), 32'(r == 0 && p == 0));
        chk("pf_bank", 32'(fb_bank), 32'(m_bank));
        if (frame_start) fs_cyc.push_back(cyc);
        acks = int'(swap_ack);
        fs_n = 0;
        n = 1;
        prev_addr = fb_rd_addr;
        prev_clk = mat_clk;
        rises = 0;
        oe_lo = 0;
        lats = 0;
        ended = 0;
        for (int i = 0; i < 200 && !ended; i++) begin
            @(negedge clk);
            n++;
            if (n == drop_en) en = 1'b0;
            if (n == 2 && exp_swap) swap_req = 1'b0;
            if (!mat_oe) oe_lo++;
            else if (oe_lo > 0) ended = 1;
            if (!ended) begin
                acks += int'(swap_ack);
                fs_n += int'(frame_start);
                if (mat_lat) begin
                    lats++;
                    chk("lat_row", 32'(mat_row), 32'(r));
                end
                if (mat_clk && !prev_clk) begin
                    c = rises;
                    if (c < COLS) begin
                        obs = {mat_b[1], mat_g[1], mat_r[1],
                               mat_b[0], mat_g[0], mat_r[0]};
                        word = ram[m_bank][r][c];
                        expv = '0;
                        for (int f = NF() - 1; f >= 0; f--)
                            expv = {expv[4:0], bit_of(32'(word), f * BITS + p)};
                        chk("col_data", 32'(obs), 32'(expv));
                        ea = {m_bank, r[RW-1:0], c[CW-1:0]};
                        chk("col_addr", 32'(prev_addr), 32'(ea));
                        if (m_bank == 1'b0 && r == 1 && c == 2)
                            chk("r1c2_rtop", 32'(mat_r[0]), 32'(bit_of(32'(pix_r), p)));
                    end
                    rises++;
                end
                prev_clk = mat_clk;
                prev_addr = fb_rd_addr;
            end
        end
        chk("plane_end_seen", 32'(ended), 1);
        chk("clk_rises", 32'(rises), 32'(COLS));
        chk("lat_cycles", 32'(lats), 1);
        chk("oe_low", 32'(oe_lo), 32'(BASE_OE << p));
        chk("plane_len", 32'(n - 1), 32'(3 + 2 * COLS + (BASE_OE << p)));
        chk("swap_acks", 32'(acks), 32'(exp_swap));
        chk("fs_extra", 32'(fs_n), 0);
        at_pf = ended && fb_rd_en && !mat_clk;
        m_idx++;
    endtask

    function automatic int NF();
        return 6;
    endfunction

    initial begin
        bit found;
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    ram[b][r][c] = DW'($urandom);
        pix_r = 2'b10;
        ram[0][1][2][BITS-1:0] = pix_r;

        rst = 1'b0;
        en = 1'b1;
        swap_req = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_oe", 32'(mat_oe), 1);
        chk("rst_lat", 32'(mat_lat), 0);
        chk("rst_clk", 32'(mat_clk), 0);
        chk("rst_bank", 32'(fb_bank), 0);
        chk("rst_rd_en", 32'(fb_rd_en), 0);
        chk("rst_rgb", 32'({mat_r, mat_g, mat_b}), 0);

        rst = 1'b1;
        m_idx = 0;
        m_bank = 1'b0;
        at_pf = 0;
        for (int k = 0; k < 4; k++) scan_plane(1'b0, -1);
        scan_plane(1'b0, -1);
        swap_req = 1'b1;
        for (int k = 0; k < 3; k++) scan_plane(1'b0, -1);
        chk("fs_count", 32'(fs_cyc.size() >= 2), 1);
        if (fs_cyc.size() >= 2)
            chk("fs_period", 32'(fs_cyc[1] - fs_cyc[0]), 32'(FRAME));

        scan_plane(1'b1, -1);
        chk("swap_req_dropped", 32'(swap_req), 0);

        scan_plane(1'b0, 5);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("idle_oe", 32'(mat_oe), 1);
            chk("idle_rd_en", 32'(fb_rd_en), 0);
            chk("idle_clk", 32'(mat_clk), 0);
        end
        en = 1'b1;
        at_pf = 0;
        scan_plane(1'b0, -1);
        scan_plane(1'b0, -1);
        scan_plane(1'b0, -1);

        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            found = !mat_oe;
        end
        chk("display_seen", 32'(found), 1);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_oe", 32'(mat_oe), 1);
        chk("mid_rst_bank", 32'(fb_bank), 0);
        chk("mid_rst_rd_en", 32'(fb_rd_en), 0);
        chk("mid_rst_lat", 32'(mat_lat), 0);
        chk("mid_rst_row", 32'(mat_row), 0);
        @(negedge clk);
        rst = 1'b1;
        m_idx = 0;
        m_bank = 1'b0;
        at_pf = 0;
        scan_plane(1'b0, -1);
        scan_plane(1'b0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
